alu_control_seq: RTL and testbench

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

---
 rtl/alu_control_seq_if.sv | 43 ++++
 rtl/alu_control_seq.sv | 135 +++++++++++++
 tb/tb_alu_control_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_seq_if.sv
// Handshake bus for the ALU-control decoder: instruction in, registered decode out.
interface alu_control_seq_if #(
    parameter int unsigned CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        opcode;
    logic [5:0]        func_field;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_control;
    logic              illegal;
    logic              multi_cycle;
    logic              busy;

    // Upstream/downstream side: presents instructions and consumes results.
    modport master (
        output in_valid,
        output opcode,
        output func_field,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  alu_control,
        input  illegal,
        input  multi_cycle,
        input  busy
    );

    // Decoder side.
    modport slave (
        input  in_valid,
        input  opcode,
        input  func_field,
        input  out_ready,
        output in_ready,
        output out_valid,
        output alu_control,
        output illegal,
        output multi_cycle,
        output busy
    );
endinterface

// File: rtl/alu_control_seq.sv
// MIPS-style ALU control decoder with a valid/ready handshake and a
// multi-cycle hold-off for mult/div class operations.
module alu_control_seq #(
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_control_seq_if.slave  bus
);

    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] C_ADD  = CODE_W'(0);
    localparam logic [CODE_W-1:0] C_SUB  = CODE_W'(1);
    localparam logic [CODE_W-1:0] C_AND  = CODE_W'(2);
    localparam logic [CODE_W-1:0] C_OR   = CODE_W'(3);
    localparam logic [CODE_W-1:0] C_NOR  = CODE_W'(4);
    localparam logic [CODE_W-1:0] C_SLT  = CODE_W'(5);
    localparam logic [CODE_W-1:0] C_XOR  = CODE_W'(6);
    localparam logic [CODE_W-1:0] C_SLTU = CODE_W'(7);
    localparam logic [CODE_W-1:0] C_MUL  = CODE_W'(8);
    localparam logic [CODE_W-1:0] C_DIV  = CODE_W'(9);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CTRL_W-1:0] r_alu_control;
    logic              r_illegal;
    logic              r_multi_cycle;

    logic [CODE_W-1:0] w_code;
    logic              w_illegal;
    logic              w_multi;
    logic              w_in_ready;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt_load;

    // Instruction decode; anything not listed is illegal and maps to add.
    always_comb begin
        w_code    = C_ADD;
        w_illegal = 1'b0;
        if (bus.opcode == 6'h00) begin
            case (bus.func_field)
                6'h20, 6'h21: w_code = C_ADD;
                6'h22, 6'h23: w_code = C_SUB;
                6'h24:        w_code = C_AND;
                6'h25:        w_code = C_OR;
                6'h27:        w_code = C_NOR;
                6'h2A:        w_code = C_SLT;
                6'h26:        w_code = C_XOR;
                6'h2B:        w_code = C_SLTU;
                6'h18, 6'h19: w_code = C_MUL;
                6'h1A, 6'h1B: w_code = C_DIV;
                default:      w_illegal = 1'b1;
            endcase
        end else begin
            case (bus.opcode)
                6'h04, 6'h05: w_code = C_SUB;
                6'h08, 6'h09: w_code = C_ADD;
                6'h0A:        w_code = C_SLT;
                6'h0C:        w_code = C_AND;
                6'h0D:        w_code = C_OR;
                6'h0E:        w_code = C_XOR;
                6'h23, 6'h2B: w_code = C_ADD;
                default:      w_illegal = 1'b1;
            endcase
        end
    end

    assign w_multi    = (w_code == C_MUL) || (w_code == C_DIV);
    assign w_cnt_load = (w_code == C_DIV) ? DIV_LOAD : MUL_LOAD;

    // Ready while idle, or while holding a result that is being consumed now.
    assign w_in_ready = (r_state == S_IDLE) ||
                        ((r_state == S_HOLD) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // State, counter and decode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_alu_control <= '0;
            r_illegal     <= 1'b0;
            r_multi_cycle <= 1'b0;
        end else if (w_accept) begin
            r_alu_control <= CTRL_W'(w_code);
            r_illegal     <= w_illegal;
            r_multi_cycle <= w_multi;
            if (w_multi) begin
                r_state <= S_BUSY;
                r_cnt   <= w_cnt_load;
            end else begin
                r_state <= S_HOLD;
                r_cnt   <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_IDLE;
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == S_HOLD);
    assign bus.busy        = (r_state == S_BUSY);
    assign bus.alu_control = r_alu_control;
    assign bus.illegal     = r_illegal;
    assign bus.multi_cycle = r_multi_cycle;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed tables, corner sequences
// and random traffic against a transaction-level reference model.
module tb_alu_control_seq;

    logic clk;
    logic rst_n;

    alu_control_seq_if #(.CTRL_W(4)) bus ();
    alu_control_seq_if #(.CTRL_W(6)) bus2 ();

    alu_control_seq #(
        .CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    alu_control_seq #(
        .CTRL_W(6), .MUL_CYCLES(1), .DIV_CYCLES(8), .CNT_W(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: pending busy cycles, result on offer, last decode.
    int m_busy_left;
    bit m_out;
    int m_code;
    bit m_ill;
    bit m_multi;

    // Last sampled DUT outputs.
    bit       obs_in_ready, obs_out_valid, obs_busy, obs_ill, obs_multi;
    bit [3:0] obs_ctrl;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         code;
        bit         ill;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       output int code, output bit ill);
        ill  = 1'b0;
        code = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: code = 0;
                6'h22, 6'h23: code = 1;
                6'h24: code = 2;
                6'h25: code = 3;
                6'h27: code = 4;
                6'h2A: code = 5;
                6'h26: code = 6;
                6'h2B: code = 7;
                6'h18, 6'h19: code = 8;
                6'h1A, 6'h1B: code = 9;
                default: ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h04, 6'h05: code = 1;
                6'h08, 6'h09: code = 0;
                6'h0A: code = 5;
                6'h0C: code = 2;
                6'h0D: code = 3;
                6'h0E: code = 6;
                6'h23, 6'h2B: code = 0;
                default: ill = 1'b1;
            endcase
        end
    endfunction

    function automatic void model_reset();
        m_busy_left = 0;
        m_out       = 1'b0;
        m_code      = 0;
        m_ill       = 1'b0;
        m_multi     = 1'b0;
    endfunction

    // One clock of traffic on the main DUT, checked against the model.
    task automatic step(input bit iv, input logic [5:0] op, input logic [5:0] fn,
                        input bit ordy);
        bit exp_rdy, acc;
        int code;
        bit ill;
        @(negedge clk);
        bus.in_valid   = iv;
        bus.opcode     = op;
        bus.func_field = fn;
        bus.out_ready  = ordy;
        #1;
        obs_in_ready  = bus.in_ready;
        obs_out_valid = bus.out_valid;
        obs_busy      = bus.busy;
        obs_ill       = bus.illegal;
        obs_multi     = bus.multi_cycle;
        obs_ctrl      = bus.alu_control;
        exp_rdy = (m_busy_left == 0 && !m_out) || (m_out && ordy);
        chk("outputs{rdy,vld,busy,ill,multi,ctrl}",
            {obs_in_ready, obs_out_valid, obs_busy, obs_ill, obs_multi, obs_ctrl},
            {exp_rdy, m_out, (m_busy_left > 0), m_ill, m_multi, 4'(m_code)});
        acc = iv && exp_rdy;
        @(posedge clk);
        if (acc) begin
            ref_decode(op, fn, code, ill);
            m_code  = code;
            m_ill   = ill;
            m_multi = (code == 8 || code == 9);
            if (m_multi) begin
                m_busy_left = (code == 8) ? 4 : 8;
                m_out       = 1'b0;
            end else begin
                m_out = 1'b1;
            end
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_out = 1'b1;
        end else if (m_out && ordy) begin
            m_out = 1'b0;
        end
    endtask

    // Issue a mult/div, then measure busy cycles and latency to out_valid.
    task automatic multi_run(input logic [5:0] fn, input int n, input int code);
        int busy_cnt, lat;
        busy_cnt = 0;
        lat      = -1;
        step(1'b1, 6'h00, fn, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 6'h00, 6'h00, 1'b1);
            if (obs_out_valid) begin
                lat = c + 1;
                break;
            end
            if (obs_busy && !obs_in_ready) busy_cnt++;
        end
        chk("multi_busy_cycles", busy_cnt, n);
        chk("multi_latency", lat, n + 1);
        chk("multi_result_ctrl", obs_ctrl, code);
        chk("multi_result_flag", obs_multi, 1);
    endtask

    task automatic check_reset_values(input string name);
        chk(name, {bus.in_ready, bus.out_valid, bus.busy, bus.illegal,
                   bus.multi_cycle, bus.alu_control},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    endtask

    vec_t tbl[$];
    logic [5:0] legal_fn[16];
    logic [5:0] itype_op[10];

    initial begin
        legal_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A,
                     6'h26, 6'h2B, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h24};
        itype_op = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                     6'h23, 6'h2B};
        tbl = '{
            '{6'h00, 6'h20, 0, 1'b0}, '{6'h00, 6'h22, 1, 1'b0},
            '{6'h00, 6'h24, 2, 1'b0}, '{6'h00, 6'h25, 3, 1'b0},
            '{6'h00, 6'h27, 4, 1'b0}, '{6'h00, 6'h2A, 5, 1'b0},
            '{6'h00, 6'h26, 6, 1'b0}, '{6'h00, 6'h2B, 7, 1'b0},
            '{6'h04, 6'h00, 1, 1'b0}, '{6'h08, 6'h00, 0, 1'b0},
            '{6'h0A, 6'h00, 5, 1'b0}, '{6'h0C, 6'h00, 2, 1'b0},
            '{6'h0D, 6'h00, 3, 1'b0}, '{6'h0E, 6'h00, 6, 1'b0},
            '{6'h23, 6'h00, 0, 1'b0}, '{6'h2B, 6'h00, 0, 1'b0},
            '{6'h3F, 6'h00, 0, 1'b1}
        };

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.opcode = '0; bus.func_field = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.opcode = '0; bus2.func_field = '0; bus2.out_ready = 1'b1;
        model_reset();
        #1;
        check_reset_values("reset_values");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back decode sweep, one accept per cycle.
        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i].op, tbl[i].fn, 1'b1);
            #1;
            chk($sformatf("sweep%0d_ctrl", i), bus.alu_control, tbl[i].code);
            chk($sformatf("sweep%0d_ill", i), bus.illegal, tbl[i].ill);
            chk($sformatf("sweep%0d_vld", i), bus.out_valid, 1);
        end
        step(1'b0, 6'h00, 6'h00, 1'b1);

        multi_run(6'h18, 4, 8);
        multi_run(6'h1A, 8, 9);

        // Stall in HOLD: sub waits while add is not consumed.
        step(1'b1, 6'h00, 6'h20, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 6'h00, 6'h22, 1'b0);
            chk("stall_in_ready", obs_in_ready, 0);
            chk("stall_ctrl", obs_ctrl, 0);
        end
        step(1'b1, 6'h00, 6'h22, 1'b1);
        #1;
        chk("stall_release_ctrl", bus.alu_control, 1);
        step(1'b0, 6'h00, 6'h00, 1'b1);

        // Reset in the middle of a div count.
        step(1'b1, 6'h00, 6'h1A, 1'b1);
        step(1'b0, 6'h00, 6'h00, 1'b1);
        step(1'b0, 6'h00, 6'h00, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midbusy_reset_values");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 6'h00, 6'h24, 1'b1);
        #1;
        chk("post_reset_and_ctrl", bus.alu_control, 2);
        chk("post_reset_and_vld", bus.out_valid, 1);
        step(1'b0, 6'h00, 6'h00, 1'b1);

        // Wide control, single-cycle multiply on the second instance.
        @(negedge clk);
        bus2.in_valid = 1'b1; bus2.opcode = 6'h00; bus2.func_field = 6'h18;
        #1;
        chk("p2_in_ready", bus2.in_ready, 1);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        #1;
        chk("p2_busy", {bus2.busy, bus2.out_valid, bus2.in_ready}, 3'b100);
        @(negedge clk);
        #1;
        chk("p2_done", {bus2.busy, bus2.out_valid, bus2.multi_cycle}, 3'b011);
        chk("p2_ctrl", bus2.alu_control, 6'd8);

        // Random traffic; an instruction stays presented until accepted.
        begin
            bit       iv, ordy, pend;
            logic [5:0] op, fn;
            int r;
            pend = 1'b0;
            op = '0;
            fn = '0;
            for (int n = 0; n < 600; n++) begin
                if (!pend) begin
                    r = $urandom_range(0, 9);
                    if (r < 5) begin
                        op = 6'h00; fn = legal_fn[$urandom_range(0, 15)];
                    end else if (r < 7) begin
                        op = 6'h00; fn = 6'($urandom);
                    end else if (r < 9) begin
                        op = itype_op[$urandom_range(0, 9)]; fn = 6'($urandom);
                    end else begin
                        op = 6'($urandom); fn = 6'($urandom);
                    end
                    pend = ($urandom_range(0, 3) != 0);
                end
                iv   = pend;
                ordy = ($urandom_range(0, 3) != 0);
                step(iv, op, fn, ordy);
                if (iv && obs_in_ready) pend = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
